// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the RV32I core: launch, fill, load-use stall, redirect flush, drain, halt.
// Optional saturating stall/redirect counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int STAGES    = 5,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             redirect,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  output logic             pc_en,
  output logic             if_id_start,
  output logic             if_id_hold,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // One phase counter is shared by FILL, FLUSH and DRAIN; it restarts on every entry.
  localparam int PW = $clog2(STAGES + FLUSH_CYC + 1);
  localparam logic [PW-1:0] FILL_LAST  = PW'(STAGES - 2);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(STAGES - 3);
  localparam logic [PW-1:0] FLUSH_LAST = PW'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

  state_t        state, state_nx;
  logic [PW-1:0] phase_cnt, phase_nx;
  logic          load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx     = state;
    phase_nx     = phase_cnt;
    pc_en        = 1'b0;
    if_id_start  = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_nx = S_FILL;
          phase_nx = '0;
        end
      end
      S_FILL, S_RUN: begin
        pc_en       = 1'b1;
        if_id_start = 1'b1;
        if (halt_req) begin
          pc_en       = 1'b0;
          if_id_start = 1'b0;
          state_nx    = S_DRAIN;
          phase_nx    = '0;
        end else if (redirect) begin
          if_id_start  = 1'b0;
          id_ex_bubble = 1'b1;
          state_nx     = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
          phase_nx     = '0;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (state == S_FILL) begin
          if (phase_cnt == FILL_LAST) state_nx = S_RUN;
          else                        phase_nx = phase_cnt + 1'b1;
        end else if (!run) begin
          state_nx = S_DRAIN;
          phase_nx = '0;
        end
      end
      S_FLUSH: begin
        pc_en = 1'b1;
        if (halt_req) begin
          pc_en    = 1'b0;
          state_nx = S_DRAIN;
          phase_nx = '0;
        end else if (redirect) begin
          id_ex_bubble = 1'b1;
          phase_nx     = '0;
        end else if (phase_cnt == FLUSH_LAST) begin
          state_nx = S_RUN;
        end else begin
          phase_nx = phase_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (phase_cnt == DRAIN_LAST) state_nx = S_HALT;
        else                         phase_nx = phase_cnt + 1'b1;
      end
      S_HALT: begin
        if (!run) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign state_o = state;
  assign busy    = (state == S_FILL) || (state == S_RUN) || (state == S_FLUSH) || (state == S_DRAIN);
  assign halted  = (state == S_HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic fill_or_run, launch, stall_take, redir_take;

  assign fill_or_run = (state == S_FILL) || (state == S_RUN);
  assign launch      = (state == S_IDLE) && run;
  assign stall_take  = fill_or_run && !halt_req && !redirect && load_use;
  assign redir_take  = (fill_or_run || (state == S_FLUSH)) && !halt_req && redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (launch) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_take && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (redir_take && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
